// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Purpose  : Shared state encoding and helpers for the round-robin mux arbiter
// Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

  // FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } arb_state_e;

  // Ceiling log2, used to size select and counter fields at elaboration
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter_if
// Purpose  : Requester/arbiter bus: requests and data in, grant and muxed
//            data out
// Revision : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import rr_arb_pkg::*;

  localparam int SW = clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic [W-1:0]   data_out;
  logic           out_valid;
  logic           busy;

  // Requester side / environment
  modport master (
    output req, data_in,
    input  gnt, sel, data_out, out_valid, busy
  );

  // Arbiter side
  modport slave (
    input  req, data_in,
    output gnt, sel, data_out, out_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter_mux_tree.sv
`default_nettype none
// ============================================================================
// Module   : mux_tree
// Purpose  : Combinational N:1 mux of W-bit words built from 2:1 cells,
//            one tree level per select bit (MSB at the root)
// Revision : 1.0 - initial release
// ============================================================================
module mux_tree
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0]        data_in,
  input  logic [clog2(N)-1:0]   sel,
  output logic [W-1:0]          y
);

  localparam int L = clog2(N);

  // Heap-ordered nodes: node[1] is the root, node[N+i] is leaf i,
  // children of node k are 2k and 2k+1.
  logic [W-1:0] node [1:2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N+i] = data_in[i*W +: W];
  end

  // Depth d splits on select bit L-1-d, so the leaf index equals sel
  for (genvar d = 0; d < L; d++) begin : g_level
    for (genvar p = 0; p < (1 << d); p++) begin : g_node
      localparam int K = (1 << d) + p;
      assign node[K] = sel[L-1-d] ? node[2*K+1] : node[2*K];
    end
  end

  assign y = node[1];

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Round-robin arbiter sharing one W-bit channel among N requesters,
//            with a fairness hold limit and a registered mux-tree output
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);

  localparam int SW = clog2(N);
  // A one-cycle hold limit still needs a one-bit counter field
  localparam int HW = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
  localparam logic [SW-1:0] LAST_RST = SW'(N - 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [SW-1:0]  last_q, last_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   mux_out;
  logic [SW-1:0]  pick_idle;
  logic [SW-1:0]  pick_grant;
  logic           release_now;

  // First requester after base, scanning base+1 .. base+N (base itself last).
  // N is a power of two, so SW-bit addition wraps modulo N for free.
  function automatic logic [SW-1:0] pick_f(input logic [SW-1:0] base,
                                           input logic [N-1:0]  r);
    logic [SW-1:0] idx;
    logic [SW-1:0] win;
    win = base;
    for (int k = N; k >= 1; k--) begin
      idx = base + SW'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  mux_tree #(
    .N (N),
    .W (W)
  ) u_mux_tree (
    .data_in (bus.data_in),
    .sel     (sel_q),
    .y       (mux_out)
  );

  assign pick_idle  = pick_f(last_q, bus.req);
  assign pick_grant = pick_f(sel_q, bus.req);

  // Drop the grant when the owner lets go, or when it has used its hold
  // budget and someone else is waiting.
  assign release_now = !bus.req[sel_q] ||
                       ((hold_q == HOLD_LIM) && ((bus.req & ~gnt_q) != '0));

  // Next-state, grant, hold counter and output data computation
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (bus.req != '0) begin
          gnt_d[pick_idle] = 1'b1;
          sel_d            = pick_idle;
          last_d           = pick_idle;
          hold_d           = '0;
          state_d          = S_GRANT;
        end
      end

      S_GRANT: begin
        data_out_d  = mux_out;
        out_valid_d = bus.req[sel_q];
        if (release_now) begin
          if (bus.req != '0) begin
            // Back-to-back regrant: no idle bubble on gnt
            gnt_d             = '0;
            gnt_d[pick_grant] = 1'b1;
            sel_d             = pick_grant;
            last_d            = pick_grant;
            hold_d            = '0;
          end else begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      last_q      <= LAST_RST;
      hold_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed self-checking bench for rr_mux_arbiter (N=4, W=8,
//            MAX_HOLD=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] dbytes [4];

  rr_mux_arbiter_if #(.N(4), .W(8)) bus ();

  rr_mux_arbiter #(
    .N        (4),
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dbytes[0] = 8'hA5;
    dbytes[1] = 8'h3C;
    dbytes[2] = 8'hC3;
    dbytes[3] = 8'h7E;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.data_in = {dbytes[3], dbytes[2], dbytes[1], dbytes[0]};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt",       32'(bus.gnt),       32'h0);
    chk("rst_sel",       32'(bus.sel),       32'h0);
    chk("rst_data_out",  32'(bus.data_out),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);

    // Single requester 0: grant after one edge, data after two
    bus.req = 4'b0001;
    tick();
    chk("t1_gnt",       32'(bus.gnt),       32'h1);
    chk("t1_sel",       32'(bus.sel),       32'h0);
    chk("t1_busy",      32'(bus.busy),      32'h1);
    chk("t1_ov_early",  32'(bus.out_valid), 32'h0);
    tick();
    chk("t1_data_out",  32'(bus.data_out),  32'hA5);
    chk("t1_out_valid", 32'(bus.out_valid), 32'h1);

    // All requests drop: idle and out_valid low on the same edge
    bus.req = 4'b0000;
    tick();
    chk("t6_gnt",       32'(bus.gnt),       32'h0);
    chk("t6_busy",      32'(bus.busy),      32'h0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'h0);

    // Fresh reset so requester 0 wins first, then full rotation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("t2_gnt_g%0d_c%0d", g, c), 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
        if (c == 1) begin
          chk($sformatf("t2_data_g%0d", g), 32'(bus.data_out), 32'(dbytes[g % 4]));
          chk($sformatf("t2_ov_g%0d", g),   32'(bus.out_valid), 32'h1);
        end
      end
    end

    // Owner 0 drops with req=1010: next in order is 1
    bus.req = 4'b1010;
    tick();
    chk("t3_gnt_to1", 32'(bus.gnt), 32'h2);
    tick();
    // Grantee 1 drops: straight to 3, no zero-grant cycle
    bus.req = 4'b1000;
    tick();
    chk("t3_gnt_to3",    32'(bus.gnt),       32'h8);
    chk("t3_busy",       32'(bus.busy),      32'h1);
    chk("t3_ov_drop",    32'(bus.out_valid), 32'h0);
    tick();
    chk("t3_data3",      32'(bus.data_out),  32'h7E);
    chk("t3_ov3",        32'(bus.out_valid), 32'h1);

    // Lone requester 2 keeps the grant indefinitely
    bus.req = 4'b0100;
    tick();
    chk("t4_gnt_first", 32'(bus.gnt), 32'h4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t4_gnt_%0d", i), 32'(bus.gnt),       32'h4);
      chk($sformatf("t4_ov_%0d", i),  32'(bus.out_valid), 32'h1);
    end
    chk("t4_hold_sat", 32'(dut.hold_q), 32'h3);
    chk("t4_data2",    32'(bus.data_out), 32'hC3);

    // Reset mid-grant, then re-arbitration restarts at requester 0
    bus.req = 4'b0101;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_gnt",       32'(bus.gnt),       32'h0);
    chk("t5_sel",       32'(bus.sel),       32'h0);
    chk("t5_data_out",  32'(bus.data_out),  32'h0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_busy",      32'(bus.busy),      32'h0);
    tick();
    chk("t5_regrant",   32'(bus.gnt),       32'h1);
    chk("t5_sel0",      32'(bus.sel),       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
